man_dist_sequencer: RTL and testbench

- Controller that sequences the combinational Manhattan-distance coprocessor for one command.
- Flow per command: accept an op byte from the command decoder, drive it onto the datapath op bus, hold it until the adder tree has settled, capture the 19-bit result, then stream it LSB-first as 3 bytes to the UART transmitter.
- Sits between the command decoder / UART TX and the distance datapath. Arbitrates so that only one calculation is in flight at a time.

---
 rtl/coproc_pkg.sv | 23 ++
 rtl/result_serializer.sv | 89 ++++++++
 rtl/man_dist_sequencer.sv | 119 +++++++++++
 tb/tb_man_dist_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the distance coprocessor: op codes, sequencer states
// and the result width in bytes.
package coproc_pkg;

   localparam logic [7:0] OP_NOP     = 8'd0;
   localparam logic [7:0] OP_LOAD_A  = 8'd97;
   localparam logic [7:0] OP_LOAD_B  = 8'd98;
   localparam logic [7:0] OP_MANDIST = 8'd103;
   localparam logic [7:0] OP_READ    = 8'd114;

   localparam int BYTES_RESULT = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WAIT_RDY,
      ST_CAPTURE,
      ST_SEND,
      ST_WAIT_TX,
      ST_DONE
   } state_e;

endpackage

// File: rtl/result_serializer.sv
// Captures a multi-byte result on start and streams it LSB-first to a UART
// transmitter using a tx_start pulse / tx_busy handshake.
module result_serializer
   import coproc_pkg::*;
#(
   parameter int NBYTES = BYTES_RESULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   data,
   input  logic                  tx_busy,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   output logic                  finished
);

   localparam int IDX_W = $clog2(NBYTES + 1);

   state_e                     st_q, st_d;
   logic [NBYTES-1:0][7:0]     cap_q, cap_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic                       seen_q, seen_d;
   logic                       gcnt_q, gcnt_d;
   logic                       last_byte;

   assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

   // tx_start is decoded from state so the byte leaves in the first SEND cycle
   assign tx_start = (st_q == ST_SEND) && !tx_busy;
   assign tx_data  = ((st_q == ST_SEND) || (st_q == ST_WAIT_TX)) ? cap_q[idx_q] : 8'h00;
   assign finished = (st_q == ST_WAIT_TX) && seen_q && !tx_busy && last_byte;

   always_comb begin
      st_d   = st_q;
      cap_d  = cap_q;
      idx_d  = idx_q;
      seen_d = seen_q;
      gcnt_d = gcnt_q;
      case (st_q)
         ST_IDLE: begin
            if (start) begin
               cap_d = data;
               idx_d = '0;
               st_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!tx_busy) begin
               seen_d = 1'b0;
               gcnt_d = 1'b0;
               st_d   = ST_WAIT_TX;
            end
         end
         ST_WAIT_TX: begin
            // busy must be seen high (or two cycles pass) before its fall counts
            if (!seen_q) begin
               if (tx_busy || gcnt_q) seen_d = 1'b1;
               gcnt_d = 1'b1;
            end else if (!tx_busy) begin
               if (last_byte) begin
                  st_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  st_d  = ST_SEND;
               end
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_IDLE;
         cap_q  <= '0;
         idx_q  <= '0;
         seen_q <= 1'b0;
         gcnt_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cap_q  <= cap_d;
         idx_q  <= idx_d;
         seen_q <= seen_d;
         gcnt_q <= gcnt_d;
      end
   end

endmodule

// File: rtl/man_dist_sequencer.sv
// Sequences one Manhattan-distance command: drives the op, waits for the adder
// tree to settle, captures the result and hands it to the byte serializer.
module man_dist_sequencer
   import coproc_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_op,
   output logic        cmd_ready,
   output logic [7:0]  dp_op,
   input  logic        dp_calc_ready,
   input  logic [23:0] dp_result,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TO_W-1:0]    tmo_q, tmo_d;
   logic [7:0]         op_q, op_d;
   logic               err_q, err_d;
   logic               ser_start;
   logic               ser_fin;

   assign ser_start = (state_q == ST_CAPTURE);
   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign dp_op     = op_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      op_d    = op_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == OP_MANDIST) begin
                  op_d    = cmd_op;
                  cnt_d   = '0;
                  tmo_d   = '0;
                  state_d = ST_SETTLE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_WAIT_RDY;
            else                                    cnt_d   = cnt_q + 1'b1;
         end
         ST_WAIT_RDY: begin
            if (dp_calc_ready) begin
               state_d = ST_CAPTURE;
            end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               op_d    = 8'h00;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_CAPTURE: state_d = ST_SEND;
         // SEND covers the whole byte stream; the serializer tracks SEND/WAIT_TX
         ST_SEND, ST_WAIT_TX: begin
            if (ser_fin) begin
               op_d    = 8'h00;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         op_q    <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   result_serializer #(
      .NBYTES (BYTES_RESULT)
   ) u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (ser_start),
      .data     (dp_result),
      .tx_busy  (tx_busy),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .finished (ser_fin)
   );

endmodule

// File: tb/tb_man_dist_sequencer.sv
// Scoreboard bench for man_dist_sequencer: directed commands push expected
// bytes, a negedge monitor pops and compares every transmitted byte.
module tb_man_dist_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [7:0]  cmd_op;
   logic        cmd_ready;
   logic [7:0]  dp_op;
   logic        dp_calc_ready;
   logic [23:0] dp_result;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        busy;
   logic        done;
   logic        err;

   int          checks;
   int          errors;
   int          bytes_seen;
   int          err_seen;
   int          busy_cnt;
   logic [7:0]  exp_q[$];

   man_dist_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_op        (cmd_op),
      .cmd_ready     (cmd_ready),
      .dp_op         (dp_op),
      .dp_calc_ready (dp_calc_ready),
      .dp_result     (dp_result),
      .tx_data       (tx_data),
      .tx_start      (tx_start),
      .tx_busy       (tx_busy),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART model: busy for 10 cycles after each accepted tx_start
   always @(posedge clk) begin
      if (tx_start)          busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (tx_start) begin
         bytes_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_tx_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
         end else begin
            chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
         end
      end
      if (err) err_seen++;
   end

   task automatic issue(input logic [7:0] op);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic push_result(input logic [23:0] r);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
      exp_q.push_back(r[23:16]);
   endtask

   // returns cycles since the last accept edge until tx_start (bounded)
   task automatic wait_tx_start(input int budget, output int n);
      n = 0;
      while (!tx_start && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!tx_start) chk("tx_start_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("done_seen", {31'h0, done}, 32'd1);
      @(posedge clk);
      #1;
      chk("done_one_cycle", {31'h0, done}, 32'd0);
      chk("busy_after_done", {31'h0, busy}, 32'd0);
      chk("dp_op_after_done", {24'h0, dp_op}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, {31'h0, cmd_ready}, 32'd1);
      chk({tag, "_busy"},      {31'h0, busy},      32'd0);
      chk({tag, "_dp_op"},     {24'h0, dp_op},     32'd0);
      chk({tag, "_tx_start"},  {31'h0, tx_start},  32'd0);
      chk({tag, "_tx_data"},   {24'h0, tx_data},   32'd0);
      chk({tag, "_done"},      {31'h0, done},      32'd0);
      chk({tag, "_err"},       {31'h0, err},       32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int b0;
      int e0;
      checks        = 0;
      errors        = 0;
      bytes_seen    = 0;
      err_seen      = 0;
      busy_cnt      = 0;
      rst_n         = 1'b0;
      cmd_valid     = 1'b0;
      cmd_op        = 8'h00;
      dp_calc_ready = 1'b1;
      dp_result     = 24'h0;
      #23;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: basic command, 14-cycle latency, bytes LSB first
      dp_result = 24'h043A7F;
      push_result(24'h043A7F);
      b0 = bytes_seen;
      issue(8'd103);
      chk("t1_dp_op", {24'h0, dp_op}, 32'd103);
      chk("t1_cmd_ready", {31'h0, cmd_ready}, 32'd0);
      chk("t1_busy", {31'h0, busy}, 32'd1);
      wait_tx_start(100, n);
      chk("t1_latency", n, 32'd14);
      wait_done(300);
      chk("t1_byte_count", bytes_seen - b0, 32'd3);

      // 2: unknown op -> err pulse, nothing else
      b0 = bytes_seen;
      e0 = err_seen;
      issue(8'd55);
      chk("t2_err", {31'h0, err}, 32'd1);
      chk("t2_dp_op", {24'h0, dp_op}, 32'd0);
      chk("t2_cmd_ready", {31'h0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("t2_err_cleared", {31'h0, err}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("t2_no_bytes", bytes_seen - b0, 32'd0);
      chk("t2_err_pulses", err_seen - e0, 32'd1);

      // 3: calc_ready never rises -> timeout after 12+255 cycles
      dp_calc_ready = 1'b0;
      b0 = bytes_seen;
      issue(8'd103);
      n = 0;
      while (!err && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 100) chk("t3_dp_op_held", {24'h0, dp_op}, 32'd103);
      end
      chk("t3_timeout_cycles", n, 32'd267);
      chk("t3_dp_op_zero", {24'h0, dp_op}, 32'd0);
      chk("t3_cmd_ready", {31'h0, cmd_ready}, 32'd1);
      chk("t3_no_bytes", bytes_seen - b0, 32'd0);
      repeat (2) @(posedge clk);
      dp_calc_ready = 1'b1;

      // 4: command during streaming ignored
      dp_result = 24'h0A0B0C;
      push_result(24'h0A0B0C);
      b0 = bytes_seen;
      e0 = err_seen;
      issue(8'd103);
      wait_tx_start(100, n);
      @(negedge clk);
      chk("t4_cmd_ready_busy", {31'h0, cmd_ready}, 32'd0);
      cmd_valid = 1'b1;
      cmd_op    = 8'd103;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_done(300);
      chk("t4_byte_count", bytes_seen - b0, 32'd3);
      chk("t4_no_err", err_seen - e0, 32'd0);

      // 5: result changes after capture; captured value is sent
      dp_result = 24'h010203;
      push_result(24'h010203);
      b0 = bytes_seen;
      issue(8'd103);
      chk("t5_accepted", {31'h0, busy}, 32'd1);
      wait_tx_start(100, n);
      dp_result = 24'h07FFFF;
      wait_done(300);
      chk("t5_byte_count", bytes_seen - b0, 32'd3);

      // 6: async reset in WAIT_TX of byte 1, then a fresh command
      dp_result = 24'h123456;
      push_result(24'h123456);
      issue(8'd103);
      wait_tx_start(100, n);
      @(posedge clk);
      #1;
      wait_tx_start(100, n);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_async");
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dp_result = 24'h05A5A5;
      push_result(24'h05A5A5);
      b0 = bytes_seen;
      issue(8'd103);
      wait_done(400);
      chk("t6_byte_count", bytes_seen - b0, 32'd3);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
